stream_framer: RTL and testbench
================================

Name: stream_framer

Overview:
- Transmit-side counterpart of the packet-stream cleaning path: converts a raw word stream plus per-packet length descriptors into the framed 38-bit stream format {data[31:0], keep[3:0], tlast, tfirst}.
- Sits upstream of any block that consumes framed streams and guarantees every emitted packet starts with tfirst and ends with tlast.
- Packet boundaries come only from the descriptor.
- Single-beat output register with valid/ready handshakes on all channels.

Parameters:
- LEN_WIDTH, 16, width of the beat-count descriptor and the remaining-beats counter.
- ZCNT_WIDTH, 8, width of the saturating zero-length-descriptor counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clear  in  1  reset; asynchronous, active-high.
- stream_framer__len_ch  in  LEN_WIDTH  packet length in beats.
- stream_framer__len_ch_vld  in  1  descriptor valid.
- stream_framer__len_ch_rdy  out  1  descriptor accepted this cycle.
- stream_framer__data_ch  in  36  {data[31:0], keep[3:0]}; keep in bits [3:0].
- stream_framer__data_ch_vld  in  1  data valid.
- stream_framer__data_ch_rdy  out  1  data beat accepted this cycle.
- stream_framer__output_ch  out  38  {data[37:6], keep[5:2], tlast[1], tfirst[0]}.
- stream_framer__output_ch_vld  out  1  output register valid.
- stream_framer__output_ch_rdy  in  1  downstream ready.
- stream_framer__busy  out  1  high while a packet is in progress (state BODY).
- stream_framer__pkt_count  out  16  completed packets (tlast beats loaded); wraps at 2^16.
- stream_framer__zero_len_count  out  ZCNT_WIDTH  zero-length descriptors dropped; saturates at all-ones.

Behaviour:
- Reset (clear high, asynchronous):
  - state is IDLE; remaining and first are 0.
  - output_ch is 38'h0 and output_ch_vld is 0.
  - pkt_count, zero_len_count and busy are 0.
  - A packet in flight is abandoned with no tlast emitted; the partial beat in the output register is discarded.
- Output load enable: out_en = ~output_ch_vld | output_ch_rdy.
- State IDLE:
  - len_ch_rdy = len_ch_vld.
  - data_ch_rdy = 0.
  - On descriptor accept with len != 0: remaining <= len, first <= 1, state <= BODY.
  - On descriptor accept with len == 0: descriptor consumed, no beats emitted, zero_len_count increments (saturating), state stays IDLE.
- State BODY:
  - len_ch_rdy = 0.
  - data_ch_rdy = data_ch_vld & out_en. This is a combinational path from output_ch_rdy.
  - On data accept, load output register with:
    - tfirst = first.
    - tlast = (remaining == 1).
    - keep passed through when tlast; forced to 4'hF otherwise.
    - data passed through unchanged.
  - Also on data accept: first <= 0 and remaining <= remaining - 1.
  - If tlast: state <= IDLE and pkt_count increments.
- Single-beat packet (len == 1): the one beat has tfirst = 1 and tlast = 1.
- Output register:
  - output_ch_vld <= 1 on data accept.
  - Otherwise, output_ch_vld <= 0 when output_ch_rdy is high.
  - Otherwise it holds. output_ch is stable while vld is high and rdy is low.
- Latency:
  - A descriptor accepted in cycle N allows the first data accept in cycle N+1.
  - A data beat accepted in cycle N is visible on output_ch in cycle N+1.
  - Full throughput is 1 beat/cycle within a packet.
  - There is one idle cycle between packets, used for the descriptor accept.
- Simultaneous events:
  - A downstream pop and a new data accept in the same cycle are legal; the register is overwritten with the new beat and vld stays 1.
  - Descriptors are never accepted in BODY, so a new packet cannot overlap the current one.
- Wrap/saturation:
  - remaining never underflows, because BODY is exited at remaining == 1.
  - pkt_count wraps 16'hFFFF -> 0.
  - zero_len_count sticks at its max value.
- Data presented while IDLE is held off (rdy = 0); it is never dropped.

Test Plan:
- Reset then len = 3 and data words A,B,C (keep 4'h3 on C) with output_ch_rdy = 1 -> output is A {keep F, tfirst=1, tlast=0}, B {F, 0, 0}, C {3, 0, 1} on consecutive cycles; pkt_count = 1; busy is low after C.
- len = 1, data D keep 4'h1 -> single beat with tfirst = 1, tlast = 1, keep 4'h1; state returns to IDLE; next descriptor accepted the following cycle.
- len = 4 with output_ch_rdy toggling 1,0,0,1,... -> output_ch held stable while rdy is low; data_ch_rdy is low whenever the register is full and rdy is low; exactly 4 beats emitted in order, tlast only on the 4th.
- Descriptors len = 0, then 0, then 2 -> zero_len_count = 2, no output beats for the zero-length descriptors, then a 2-beat framed packet; force zero_len_count to 8'hFF and add one more len = 0 -> count stays 8'hFF.
- Assert clear after the 2nd beat of a len = 5 packet -> output_ch_vld drops immediately (asynchronous), busy = 0, counters = 0; a new len = 2 packet afterwards starts with tfirst = 1.
- Data valid held high in IDLE with no descriptor for 10 cycles -> data_ch_rdy stays 0 and no output; send len = 2 -> the held word is emitted first with tfirst = 1.

Source files
------------

// File: rtl/stream_framer.sv
`default_nettype none
// ============================================================================
// Module      : stream_framer
// Description : Frames a raw word stream into packets using per-packet beat
//               count descriptors. Emits the 38-bit framed format
//               {data[31:0], keep[3:0], tlast, tfirst} through a single-beat
//               output register with valid/ready handshaking.
// Ports       :
//   clk                           clock, rising edge
//   clear                         asynchronous active-high reset
//   stream_framer__len_ch[_vld/_rdy]     packet length descriptor (beats)
//   stream_framer__data_ch[_vld/_rdy]    raw beat {data[31:0], keep[3:0]}
//   stream_framer__output_ch[_vld/_rdy]  framed beat {data, keep, tlast, tfirst}
//   stream_framer__busy           packet in progress
//   stream_framer__pkt_count      completed packets, wraps
//   stream_framer__zero_len_count dropped zero-length descriptors, saturates
// Revision    : 1.0 - initial release
// ============================================================================
module stream_framer #(
    parameter int LEN_WIDTH  = 16,
    parameter int ZCNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [LEN_WIDTH-1:0]  stream_framer__len_ch,
    input  logic                  stream_framer__len_ch_vld,
    output logic                  stream_framer__len_ch_rdy,
    input  logic [35:0]           stream_framer__data_ch,
    input  logic                  stream_framer__data_ch_vld,
    output logic                  stream_framer__data_ch_rdy,
    output logic [37:0]           stream_framer__output_ch,
    output logic                  stream_framer__output_ch_vld,
    input  logic                  stream_framer__output_ch_rdy,
    output logic                  stream_framer__busy,
    output logic [15:0]           stream_framer__pkt_count,
    output logic [ZCNT_WIDTH-1:0] stream_framer__zero_len_count
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BODY = 1'b1;

    logic [0:0]            r_state;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_first;
    logic [37:0]           r_out;
    logic                  r_out_vld;
    logic [15:0]           r_pkt_count;
    logic [ZCNT_WIDTH-1:0] r_zcnt;

    logic       w_out_en;
    logic       w_len_acc;
    logic       w_data_acc;
    logic       w_len_zero;
    logic       w_tlast;
    logic [3:0] w_keep;

    always_comb begin
        // The output register can take a new beat when empty or when its
        // current beat is leaving this cycle.
        w_out_en   = ~r_out_vld | stream_framer__output_ch_rdy;
        w_len_acc  = (r_state == c_IDLE) & stream_framer__len_ch_vld;
        w_data_acc = (r_state == c_BODY) & stream_framer__data_ch_vld & w_out_en;
        w_len_zero = (stream_framer__len_ch == '0);
        w_tlast    = (r_remaining == LEN_WIDTH'(1));
        // Only the final beat of a packet may be partial.
        w_keep     = w_tlast ? stream_framer__data_ch[3:0] : 4'hF;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state     <= c_IDLE;
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_out       <= 38'h0;
            r_out_vld   <= 1'b0;
            r_pkt_count <= 16'h0;
            r_zcnt      <= '0;
        end else begin
            if (w_len_acc) begin
                if (w_len_zero) begin
                    if (r_zcnt != {ZCNT_WIDTH{1'b1}}) begin
                        r_zcnt <= r_zcnt + 1'b1;
                    end
                end else begin
                    r_remaining <= stream_framer__len_ch;
                    r_first     <= 1'b1;
                    r_state     <= c_BODY;
                end
            end

            if (w_data_acc) begin
                r_out       <= {stream_framer__data_ch[35:4], w_keep, w_tlast, r_first};
                r_out_vld   <= 1'b1;
                r_first     <= 1'b0;
                r_remaining <= r_remaining - 1'b1;
                if (w_tlast) begin
                    r_state     <= c_IDLE;
                    r_pkt_count <= r_pkt_count + 16'h1;
                end
            end else if (stream_framer__output_ch_rdy) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign stream_framer__len_ch_rdy      = w_len_acc;
    assign stream_framer__data_ch_rdy     = w_data_acc;
    assign stream_framer__output_ch       = r_out;
    assign stream_framer__output_ch_vld   = r_out_vld;
    assign stream_framer__busy            = (r_state == c_BODY);
    assign stream_framer__pkt_count       = r_pkt_count;
    assign stream_framer__zero_len_count  = r_zcnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_stream_framer
// Description : Self-checking bench for stream_framer. Packets are described
//               as a length plus a list of raw words; the expected framed
//               beats are derived from that description.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_framer;
    localparam int LW = 16;
    localparam int ZW = 8;

    logic          clk = 1'b0;
    logic          clear;
    logic [LW-1:0] len_ch;
    logic          len_vld;
    logic          len_rdy;
    logic [35:0]   data_ch;
    logic          data_vld;
    logic          data_rdy;
    logic [37:0]   out_data;
    logic          out_vld;
    logic          out_rdy;
    logic          busy;
    logic [15:0]   pkt_count;
    logic [ZW-1:0] zcnt;

    stream_framer #(.LEN_WIDTH(LW), .ZCNT_WIDTH(ZW)) dut (
        .clk                           (clk),
        .clear                         (clear),
        .stream_framer__len_ch         (len_ch),
        .stream_framer__len_ch_vld     (len_vld),
        .stream_framer__len_ch_rdy     (len_rdy),
        .stream_framer__data_ch        (data_ch),
        .stream_framer__data_ch_vld    (data_vld),
        .stream_framer__data_ch_rdy    (data_rdy),
        .stream_framer__output_ch      (out_data),
        .stream_framer__output_ch_vld  (out_vld),
        .stream_framer__output_ch_rdy  (out_rdy),
        .stream_framer__busy           (busy),
        .stream_framer__pkt_count      (pkt_count),
        .stream_framer__zero_len_count (zcnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    longint      cyc = 0;
    logic [37:0] exp_q[$];
    logic [37:0] obs_q[$];
    longint      obs_cyc[$];
    logic [35:0] pkt_words[$];
    int          rdy_mode = 0;
    bit          bubbles = 0;
    int          stab_err = 0;
    int          bp_err = 0;
    int          idle_err = 0;
    int          stall_seen = 0;
    int          exp_pkt = 0;
    int          exp_zcnt = 0;
    logic        prev_hold;
    logic [37:0] prev_out;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready: 0 = always ready, 1 = ready one cycle in three, 2 = random.
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = (cyc % 3 == 0);
                default: out_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Collects delivered beats and records protocol violations for the tests.
    initial begin
        prev_hold = 1'b0;
        prev_out  = '0;
        forever begin
            @(negedge clk);
            if (clear) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && (!out_vld || out_data !== prev_out)) stab_err++;
                if (out_vld && !out_rdy && data_rdy) bp_err++;
                if (!busy && data_rdy) idle_err++;
                if (out_vld && !out_rdy) stall_seen++;
                if (out_vld && out_rdy) begin
                    obs_q.push_back(out_data);
                    obs_cyc.push_back(cyc);
                end
                prev_hold = out_vld && !out_rdy;
                prev_out  = out_data;
            end
        end
    end

    // Reference: a packet of L words becomes L beats; the first carries tfirst,
    // the last carries tlast and its own keep, every other keep reads 4'hF.
    task automatic model_packet(input int len);
        logic [35:0] w;
        logic [3:0]  k;
        if (len == 0) begin
            if (exp_zcnt < 255) exp_zcnt++;
        end else begin
            for (int i = 0; i < len; i++) begin
                w = pkt_words[i];
                k = (i == len - 1) ? w[3:0] : 4'hF;
                exp_q.push_back({w[35:4], k, (i == len - 1), (i == 0)});
            end
            exp_pkt++;
        end
    endtask

    task automatic send_packet(input int len);
        model_packet(len);
        fork
            begin
                int t = 0;
                len_ch  = len[LW-1:0];
                len_vld = 1'b1;
                do begin
                    @(negedge clk);
                    t++;
                end while (!len_rdy && t < 1000);
                if (!len_rdy) begin
                    n_cmp++; n_fail++;
                    $display("FAIL desc_accept: len_rdy=%0b required 1 within 1000 cycles", len_rdy);
                end
                @(posedge clk);
                #1;
                len_vld = 1'b0;
            end
            begin
                for (int i = 0; i < len; i++) begin
                    int t = 0;
                    if (bubbles && ($urandom % 3 == 0)) begin
                        data_vld = 1'b0;
                        repeat ($urandom_range(1, 2)) @(posedge clk);
                        #1;
                    end
                    data_ch  = pkt_words[i];
                    data_vld = 1'b1;
                    do begin
                        @(negedge clk);
                        t++;
                    end while (!data_rdy && t < 1000);
                    if (!data_rdy) begin
                        n_cmp++; n_fail++;
                        $display("FAIL data_accept: data_rdy=%0b required 1 within 1000 cycles", data_rdy);
                    end
                    @(posedge clk);
                    #1;
                end
                data_vld = 1'b0;
            end
        join
    endtask

    task automatic drain();
        int t = 0;
        while (obs_q.size() < exp_q.size() && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic start_scenario();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        pkt_words.delete();
    endtask

    task automatic test_reset();
        clear = 1'b1; len_ch = '0; len_vld = 1'b0; data_ch = '0; data_vld = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_data !== 38'h0 || out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: data=%h vld=%0b required 0/0", out_data, out_vld);
        end
        n_cmp++;
        if (busy !== 1'b0 || pkt_count !== 16'h0 || zcnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%0b pkt=%0d zcnt=%0d required 0/0/0", busy, pkt_count, zcnt);
        end
        n_cmp++;
        if (len_rdy !== 1'b0 || data_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdy: len_rdy=%0b data_rdy=%0b required 0/0", len_rdy, data_rdy);
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        start_scenario();
        rdy_mode = 0;
        pkt_words.push_back({32'hA0A0_0001, 4'h5});
        pkt_words.push_back({32'hB0B0_0002, 4'h0});
        pkt_words.push_back({32'hC0C0_0003, 4'h3});
        send_packet(3);
        drain();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < obs_cyc.size(); i++) begin
            n_cmp++;
            if (obs_cyc[i] != obs_cyc[i-1] + 1) begin
                n_fail++;
                $display("FAIL basic_throughput: beat%0d at cycle %0d required %0d", i, obs_cyc[i], obs_cyc[i-1] + 1);
            end
        end
        n_cmp++;
        if (pkt_count !== 16'(exp_pkt) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_status: pkt=%0d busy=%0b required %0d/0", pkt_count, busy, exp_pkt);
        end
    endtask

    task automatic test_single();
        start_scenario();
        rdy_mode = 0;
        pkt_words.push_back({32'hD0D0_0004, 4'h1});
        send_packet(1);
        // Next descriptor presented the cycle right after the single beat.
        len_ch  = '0;
        len_vld = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || len_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_next_desc: busy=%0b len_rdy=%0b required 0/1", busy, len_rdy);
        end
        if (exp_zcnt < 255) exp_zcnt++;
        @(posedge clk);
        #1;
        len_vld = 1'b0;
        drain();
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL single_beat: got %0d beats first %h required 1 beat %h", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : 38'h0, exp_q[0]);
        end
        n_cmp++;
        if (zcnt !== ZW'(exp_zcnt) || pkt_count !== 16'(exp_pkt)) begin
            n_fail++;
            $display("FAIL single_counts: zcnt=%0d pkt=%0d required %0d/%0d", zcnt, pkt_count, exp_zcnt, exp_pkt);
        end
    endtask

    task automatic test_backpressure();
        start_scenario();
        rdy_mode = 1;
        stab_err = 0; bp_err = 0; stall_seen = 0;
        for (int i = 0; i < 4; i++) pkt_words.push_back({$urandom, 4'($urandom)});
        send_packet(4);
        drain();
        rdy_mode = 0;
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (stab_err !== 0 || bp_err !== 0 || stall_seen == 0) begin
            n_fail++;
            $display("FAIL bp_protocol: unstable=%0d accept_while_full=%0d stalls=%0d required 0/0/>0",
                     stab_err, bp_err, stall_seen);
        end
    endtask

    task automatic test_zero_len();
        start_scenario();
        rdy_mode = 0;
        send_packet(0);
        send_packet(0);
        pkt_words.push_back({$urandom, 4'h7});
        pkt_words.push_back({$urandom, 4'hE});
        send_packet(2);
        drain();
        n_cmp++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL zlen_count: got %0d beats required 2", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL zlen_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (zcnt !== ZW'(exp_zcnt)) begin
            n_fail++;
            $display("FAIL zlen_counter: got %0d required %0d", zcnt, exp_zcnt);
        end
        for (int i = 0; i < 300; i++) send_packet(0);
        @(negedge clk);
        n_cmp++;
        if (zcnt !== ZW'(exp_zcnt) || exp_zcnt != 255) begin
            n_fail++;
            $display("FAIL zlen_saturate: got %0d required %0d", zcnt, exp_zcnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        start_scenario();
        rdy_mode = 2;
        bubbles  = 1;
        stab_err = 0; bp_err = 0; idle_err = 0;
        for (int p = 0; p < 25; p++) begin
            int len;
            len = $urandom_range(0, 7);
            pkt_words.delete();
            for (int i = 0; i < len; i++) pkt_words.push_back({$urandom, 4'($urandom)});
            send_packet(len);
        end
        drain();
        bubbles  = 0;
        rdy_mode = 0;
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d beats required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (pkt_count !== 16'(exp_pkt) || zcnt !== ZW'(exp_zcnt)) begin
            n_fail++;
            $display("FAIL rand_counts: pkt=%0d zcnt=%0d required %0d/%0d", pkt_count, zcnt, exp_pkt, exp_zcnt);
        end
        n_cmp++;
        if (stab_err !== 0 || bp_err !== 0 || idle_err !== 0) begin
            n_fail++;
            $display("FAIL rand_protocol: unstable=%0d accept_while_full=%0d idle_accept=%0d required 0/0/0",
                     stab_err, bp_err, idle_err);
        end
    endtask

    task automatic test_idle_hold();
        logic [35:0] held;
        start_scenario();
        rdy_mode = 0;
        held     = {$urandom, 4'h9};
        data_ch  = held;
        data_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (data_rdy !== 1'b0 || obs_q.size() != 0) begin
                n_fail++;
                $display("FAIL idle_hold_c%0d: data_rdy=%0b beats=%0d required 0/0", i, data_rdy, obs_q.size());
            end
        end
        @(posedge clk);
        #1;
        pkt_words.push_back(held);
        pkt_words.push_back({$urandom, 4'hC});
        send_packet(2);
        drain();
        n_cmp++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL idle_count: got %0d beats required 2", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL idle_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clear();
        start_scenario();
        rdy_mode = 0;
        len_ch   = LW'(5);
        len_vld  = 1'b1;
        @(posedge clk);
        #1;
        len_vld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_ch  = {$urandom, 4'h2};
            data_vld = 1'b1;
            @(posedge clk);
            #1;
        end
        data_vld = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || out_vld !== 1'b1 || pkt_count !== 16'(exp_pkt)) begin
            n_fail++;
            $display("FAIL clear_pre: busy=%0b vld=%0b pkt=%0d required 1/1/%0d", busy, out_vld, pkt_count, exp_pkt);
        end
        #2;
        clear = 1'b1;
        #1;
        n_cmp++;
        if (out_vld !== 1'b0 || out_data !== 38'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_async: vld=%0b data=%h busy=%0b required 0/0/0", out_vld, out_data, busy);
        end
        n_cmp++;
        if (pkt_count !== 16'h0 || zcnt !== '0) begin
            n_fail++;
            $display("FAIL clear_counters: pkt=%0d zcnt=%0d required 0/0", pkt_count, zcnt);
        end
        @(posedge clk);
        #1;
        clear    = 1'b0;
        exp_pkt  = 0;
        exp_zcnt = 0;
        start_scenario();
        pkt_words.push_back({$urandom, 4'h4});
        pkt_words.push_back({$urandom, 4'h8});
        send_packet(2);
        drain();
        n_cmp++;
        if (obs_q.size() != 2 || obs_q[0][0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_restart: beats=%0d first_tfirst=%0b required 2/1", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0][0] : 1'b0);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL clear_beat%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (pkt_count !== 16'(exp_pkt)) begin
            n_fail++;
            $display("FAIL clear_pkt: got %0d required %0d", pkt_count, exp_pkt);
        end
    endtask

    initial begin
        clear = 1'b1; len_ch = '0; len_vld = 1'b0; data_ch = '0; data_vld = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_backpressure();
        test_zero_len();
        test_random();
        test_idle_hold();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
